// File: rtl/btn_pkg.sv
// Shared definitions for the push-button pulse detector: edge-mode encoding,
// the debounce/hold counter width helper and the edge-mode legality check.
package btn_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  // Bits needed for a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Only rise, fall and both are meaningful edge selections.
  function automatic bit edge_mode_ok(input int mode);
    return (mode >= int'(EDGE_RISE)) && (mode <= int'(EDGE_BOTH));
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchroniser, stability-count debounce,
// registered rise/fall strobes and, with BTN_PULSE_REPEAT_EN defined,
// auto-repeat strobes while the debounced level stays high.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int REPEAT_CYCLES   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall,
  output logic hold
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          accept;

  // A new level is taken on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
  assign accept = (s2 != level) && (cnt == CNT_LAST);

  // Bring the raw button level into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Debounce: any sample matching the current level restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= accept & s2;
      fall <= accept & ~s2;
      if (s2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef BTN_PULSE_REPEAT_EN
  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - REPEAT_CYCLES);

  logic [HW-1:0] hcnt;

  // hcnt counts cycles since the rise strobe; it is checked one count early so
  // the first repeat lands exactly HOLD_CYCLES cycles after the rise cycle.
  // An accepted transition clears it, so no repeat strobe ever coincides with fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      hold <= 1'b0;
    end else if (!level || accept) begin
      hcnt <= '0;
      hold <= 1'b0;
    end else if (hcnt == HOLD_LAST) begin
      hcnt <= HOLD_RELOAD;
      hold <= 1'b1;
    end else begin
      hcnt <= hcnt + HW'(1);
      hold <= 1'b0;
    end
  end
`else
  assign hold = 1'b0;
`endif

endmodule

// File: rtl/btn_pulse_detector.sv
// Multi-channel push-button front end: CHANNELS independent debounced
// channels, each giving level, rise/fall strobes and optional repeat strobes.
// Optional feature macro: BTN_PULSE_REPEAT_EN (auto-repeat while held).
module btn_pulse_detector
  import btn_pkg::*;
#(
  parameter int CHANNELS        = 5,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_MODE       = 0,
  parameter int HOLD_CYCLES     = 8,
  parameter int REPEAT_CYCLES   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_signal,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] hold,
  output logic [CHANNELS-1:0] out
);

  logic [CHANNELS-1:0] edge_sel;

  // Parameter sanity is checked at elaboration so a bad build never reaches silicon.
  if (!edge_mode_ok(EDGE_MODE)) begin : g_bad_mode
    $error("btn_pulse_detector: EDGE_MODE must be 0, 1 or 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("btn_pulse_detector: DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_CYCLES < 1 || REPEAT_CYCLES > HOLD_CYCLES) begin : g_bad_repeat
    $error("btn_pulse_detector: REPEAT_CYCLES must be within 1..HOLD_CYCLES");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn_signal[i]),
      .level(level[i]),
      .rise (rise[i]),
      .fall (fall[i]),
      .hold (hold[i])
    );
  end

  if (EDGE_MODE == int'(EDGE_RISE)) begin : g_sel_rise
    assign edge_sel = rise;
  end else if (EDGE_MODE == int'(EDGE_FALL)) begin : g_sel_fall
    assign edge_sel = fall;
  end else begin : g_sel_both
    assign edge_sel = rise | fall;
  end

  // Every term is a flop output, so out stays glitch-free one-cycle strobes.
  assign out = edge_sel | hold;

endmodule

// File: tb/tb_btn_pulse_detector.sv
// Self-checking bench for btn_pulse_detector: two instances (rising-edge and
// both-edge selection) share one stimulus, an abstract model is compared every
// cycle, and directed steps pin the model with literal expectations.
module tb_btn_pulse_detector;

  localparam int CH   = 2;
  localparam int DB   = 4;
  localparam int HOLD = 8;
  localparam int REP  = 2;
`ifdef BTN_PULSE_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [CH-1:0] btn_signal = '0;

  logic [CH-1:0] level_a, rise_a, fall_a, hold_a, out_a;
  logic [CH-1:0] level_b, rise_b, fall_b, hold_b, out_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_pulse_detector #(.CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .EDGE_MODE(0),
                       .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut_a (
    .clk(clk), .rst_n(rst_n), .btn_signal(btn_signal),
    .level(level_a), .rise(rise_a), .fall(fall_a), .hold(hold_a), .out(out_a));

  btn_pulse_detector #(.CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .EDGE_MODE(2),
                       .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut_b (
    .clk(clk), .rst_n(rst_n), .btn_signal(btn_signal),
    .level(level_b), .rise(rise_b), .fall(fall_b), .hold(hold_b), .out(out_b));

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a level is accepted once the last DB synchronised samples all equal
  // the opposite of the current level; repeats fall at HOLD, HOLD+REP, ...
  // cycles after the rise cycle while the level remains high.
  logic [CH-1:0] m_s1 = '0, m_s2 = '0, m_level = '0, m_rise = '0, m_fall = '0, m_hold = '0;
  logic [7:0]    m_win [CH];
  int            m_age [CH];

  always @(posedge clk or negedge rst_n) begin
    logic [CH-1:0] t_level, t_rise, t_fall, t_hold;
    logic [7:0]    t_win;
    int            t_age;
    logic          s;
    logic          acc;
    if (!rst_n) begin
      m_s1 <= '0; m_s2 <= '0; m_level <= '0;
      m_rise <= '0; m_fall <= '0; m_hold <= '0;
      for (int c = 0; c < CH; c++) begin
        m_win[c] <= '0;
        m_age[c] <= 0;
      end
    end else begin
      t_level = m_level;
      t_rise  = '0;
      t_fall  = '0;
      t_hold  = '0;
      for (int c = 0; c < CH; c++) begin
        s     = m_s2[c];
        t_win = {m_win[c][6:0], s};
        acc   = (s != m_level[c]);
        for (int k = 0; k < DB; k++)
          if (t_win[k] != s) acc = 1'b0;
        t_rise[c] = acc & s;
        t_fall[c] = acc & ~s;
        t_age = m_age[c];
        if (acc && s) begin
          t_age = 0;
        end else if (!acc && m_level[c]) begin
          t_age = t_age + 1;
          t_hold[c] = REPEAT_EN && (t_age >= HOLD) && (((t_age - HOLD) % REP) == 0);
        end
        if (acc) t_level[c] = s;
        m_win[c] <= t_win;
        m_age[c] <= t_age;
      end
      m_level <= t_level;
      m_rise  <= t_rise;
      m_fall  <= t_fall;
      m_hold  <= t_hold;
      m_s2    <= m_s1;
      m_s1    <= btn_signal;
    end
  end

  // Every cycle, away from the active edge, both instances must match the model.
  always @(negedge clk) begin
    check("model_level_a", level_a, m_level);
    check("model_rise_a",  rise_a,  m_rise);
    check("model_fall_a",  fall_a,  m_fall);
    check("model_hold_a",  hold_a,  m_hold);
    check("model_out_a",   out_a,   m_rise | m_hold);
    check("model_level_b", level_b, m_level);
    check("model_rise_b",  rise_b,  m_rise);
    check("model_fall_b",  fall_b,  m_fall);
    check("model_hold_b",  hold_b,  m_hold);
    check("model_out_b",   out_b,   m_rise | m_fall | m_hold);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [CH-1:0] e_rise, e_fall, e_hold;
    #1;
    btn_signal = 2'b11;
    rst_n = 1'b0;
    tick(3);
    check("rst_level", level_a, 2'b00);
    check("rst_rise",  rise_a,  2'b00);
    check("rst_fall",  fall_a,  2'b00);
    check("rst_hold",  hold_a,  2'b00);
    check("rst_out_a", out_a,   2'b00);
    check("rst_out_b", out_b,   2'b00);

    // Input already high at release: rise on both channels after edge 6.
    rst_n = 1'b1;
    tick(5);
    check("release_rise_e5", rise_a, 2'b00);
    tick(1);
    check("release_rise_e6",  rise_a,  2'b11);
    check("release_level_e6", level_a, 2'b11);
    tick(1);
    check("release_rise_e7", rise_a, 2'b00);
    btn_signal = 2'b00;
    tick(12);

    // Clean press on channel 0 only.
    btn_signal = 2'b01;
    tick(5);
    check("press_level_e5", level_a, 2'b00);
    tick(1);
    check("press_level_e6", level_a, 2'b01);
    check("press_rise_e6",  rise_a,  2'b01);
    tick(1);
    check("press_rise_e7", rise_a, 2'b00);
    btn_signal = 2'b00;
    tick(12);

    // Three-cycle glitch is discarded.
    btn_signal = 2'b01;
    tick(3);
    btn_signal = 2'b00;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("glitch_level", level_a, 2'b00);
      check("glitch_rise",  rise_a,  2'b00);
      check("glitch_out",   out_a,   2'b00);
    end

    // Four-cycle pulse is just long enough.
    btn_signal = 2'b01;
    tick(4);
    btn_signal = 2'b00;
    tick(2);
    check("pulse4_rise_e6", rise_a, 2'b01);
    tick(12);

    // Long hold then release before edge 21: fall after edge 26.
    btn_signal = 2'b01;
    for (int e = 1; e <= 30; e++) begin
      tick(1);
      e_rise = (e == 6)  ? 2'b01 : 2'b00;
      e_fall = (e == 26) ? 2'b01 : 2'b00;
      e_hold = (REPEAT_EN && e >= 14 && e <= 24 && (e % 2) == 0) ? 2'b01 : 2'b00;
      check("held_rise",   rise_a, e_rise);
      check("held_fall",   fall_a, e_fall);
      check("held_hold",   hold_a, e_hold);
      check("held_out_b",  out_b,  e_rise | e_fall | e_hold);
      if (e == 20) btn_signal = 2'b00;
    end
    tick(4);

    // Reset while the debounce count is at 2: progress is lost.
    btn_signal = 2'b01;
    tick(4);
    rst_n = 1'b0;
    tick(2);
    check("midrst_level", level_a, 2'b00);
    check("midrst_rise",  rise_a,  2'b00);
    rst_n = 1'b1;
    tick(5);
    check("midrst_rise_e5", rise_a, 2'b00);
    tick(1);
    check("midrst_rise_e6",  rise_a,  2'b01);
    check("midrst_level_e6", level_a, 2'b01);
    tick(3);
    btn_signal = 2'b00;
    tick(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
